oled_init_sequencer: RTL and testbench

Transaction scheduler that brings up the SSD1306 OLED over I2C by feeding a byte-level I2C master one byte at a time. On a `go` pulse it sends the fixed power-up command script as one write transaction, optionally clears the 128x64 GDDRAM, and reports done or error. It sits between top-level control and the I2C byte engine, and owns all slave address, control byte and command byte selection.

---
 rtl/oled_pkg.sv | 30 +++
 rtl/oled_init_rom.sv | 47 ++++
 rtl/oled_init_sequencer.sv | 177 +++++++++++++++++
 tb/tb_oled_init_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared state encodings and protocol constants for the SSD1306 bring-up sequencer.
// The CLR_* states exist only when OLED_CLEAR_EN is defined.
package oled_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT_ADDR = 4'd1,
        INIT_CTRL = 4'd2,
        INIT_CMD  = 4'd3,
        WAIT_ACK  = 4'd4,
        FINISH    = 4'd5,
        FAIL      = 4'd6
`ifdef OLED_CLEAR_EN
        ,
        CLR_ADDR  = 4'd7,
        CLR_CTRL  = 4'd8,
        CLR_DATA  = 4'd9
`endif
    } state_t;

    localparam logic [7:0] OLED_ADDR_W  = 8'h78;
    localparam logic [7:0] CTRL_CMD     = 8'h00;
    localparam logic [7:0] CTRL_DATA    = 8'h40;
    localparam int         INIT_LEN     = 31;
    localparam int         GDDRAM_BYTES = 1024;

    localparam logic [4:0]  ROM_LAST  = 5'(INIT_LEN - 1);
    localparam logic [10:0] DATA_LAST = 11'(GDDRAM_BYTES - 1);

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command script as a combinational lookup; indices past the
// script return the controller's NOP command.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] data
);

    always_comb begin
        case (idx)
            5'd0:    data = 8'hAE;
            5'd1:    data = 8'hD5;
            5'd2:    data = 8'h80;
            5'd3:    data = 8'hA8;
            5'd4:    data = 8'h3F;
            5'd5:    data = 8'hD3;
            5'd6:    data = 8'h00;
            5'd7:    data = 8'h40;
            5'd8:    data = 8'h8D;
            5'd9:    data = 8'h14;
            5'd10:   data = 8'h20;
            5'd11:   data = 8'h00;
            5'd12:   data = 8'h21;
            5'd13:   data = 8'h00;
            5'd14:   data = 8'h7F;
            5'd15:   data = 8'h22;
            5'd16:   data = 8'h00;
            5'd17:   data = 8'h07;
            5'd18:   data = 8'hA1;
            5'd19:   data = 8'hC8;
            5'd20:   data = 8'hDA;
            5'd21:   data = 8'h12;
            5'd22:   data = 8'h81;
            5'd23:   data = 8'h7F;
            5'd24:   data = 8'hD9;
            5'd25:   data = 8'hF1;
            5'd26:   data = 8'hDB;
            5'd27:   data = 8'h40;
            5'd28:   data = 8'hA4;
            5'd29:   data = 8'hA6;
            5'd30:   data = 8'hAF;
            default: data = 8'hE3;
        endcase
    end

endmodule

// File: rtl/oled_init_sequencer.sv
// Drives a byte-level I2C master through the SSD1306 init write, with whole-transaction
// retry on NACK. Define OLED_CLEAR_EN to append a full GDDRAM clear transaction.
module oled_init_sequencer
    import oled_pkg::*;
#(
    parameter int RETRY_MAX = 3
)
(
    input  logic       CLK,
    input  logic       NRST,
    input  logic       go,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    output logic       tx_stop,
    input  logic       ack_valid,
    input  logic       ack_nack,
    output logic       busy,
    output logic       done,
    output logic       error
);

    state_t      state, state_next;
    state_t      ret_state, ret_next;
    logic [4:0]  rom_idx, rom_idx_next;
    logic [3:0]  retry_cnt, retry_next;
    logic        done_next, error_next;
    logic [7:0]  rom_byte;
`ifdef OLED_CLEAR_EN
    logic [10:0] data_cnt, data_cnt_next;
`endif

    oled_init_rom u_rom (
        .idx  (rom_idx),
        .data (rom_byte)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state     <= IDLE;
            ret_state <= IDLE;
            rom_idx   <= '0;
            retry_cnt <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef OLED_CLEAR_EN
            data_cnt  <= '0;
`endif
        end else begin
            state     <= state_next;
            ret_state <= ret_next;
            rom_idx   <= rom_idx_next;
            retry_cnt <= retry_next;
            done      <= done_next;
            error     <= error_next;
`ifdef OLED_CLEAR_EN
            data_cnt  <= data_cnt_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable written below gets a default first, so no path infers a latch.
        state_next    = state;
        ret_next      = ret_state;
        rom_idx_next  = rom_idx;
        retry_next    = retry_cnt;
        done_next     = done;
        error_next    = error;
`ifdef OLED_CLEAR_EN
        data_cnt_next = data_cnt;
`endif
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        tx_start = 1'b0;
        tx_stop  = 1'b0;
        busy     = (state != IDLE) && (state != FINISH) && (state != FAIL);

        case (state)
            IDLE, FINISH, FAIL: begin
                state_next = IDLE;
                if (go) begin
                    state_next   = INIT_ADDR;
                    rom_idx_next = '0;
                    retry_next   = '0;
                    done_next    = 1'b0;
                    error_next   = 1'b0;
                end
            end

            INIT_ADDR, INIT_CTRL, INIT_CMD: begin
                tx_valid = 1'b1;
                tx_start = (state == INIT_ADDR);
                tx_stop  = (state == INIT_CMD) && (rom_idx == ROM_LAST);
                tx_byte  = (state == INIT_ADDR) ? OLED_ADDR_W :
                           (state == INIT_CTRL) ? CTRL_CMD : rom_byte;
                if (tx_ready) begin
                    ret_next   = state;
                    state_next = WAIT_ACK;
                end
            end

`ifdef OLED_CLEAR_EN
            CLR_ADDR, CLR_CTRL, CLR_DATA: begin
                tx_valid = 1'b1;
                tx_start = (state == CLR_ADDR);
                tx_stop  = (state == CLR_DATA) && (data_cnt == DATA_LAST);
                tx_byte  = (state == CLR_ADDR) ? OLED_ADDR_W :
                           (state == CLR_CTRL) ? CTRL_DATA : 8'h00;
                if (tx_ready) begin
                    ret_next   = state;
                    state_next = WAIT_ACK;
                end
            end
`endif

            WAIT_ACK: begin
                if (ack_valid && ack_nack) begin
                    // The master has already sent STOP; restart the current transaction from its address byte.
                    if (retry_cnt < 4'(RETRY_MAX)) begin
                        retry_next   = retry_cnt + 4'd1;
                        rom_idx_next = '0;
                        state_next   = INIT_ADDR;
`ifdef OLED_CLEAR_EN
                        data_cnt_next = '0;
                        if ((ret_state == CLR_ADDR) || (ret_state == CLR_CTRL) || (ret_state == CLR_DATA))
                            state_next = CLR_ADDR;
`endif
                    end else begin
                        state_next = FAIL;
                        error_next = 1'b1;
                    end
                end else if (ack_valid) begin
                    case (ret_state)
                        INIT_ADDR: state_next = INIT_CTRL;
                        INIT_CTRL: state_next = INIT_CMD;
                        INIT_CMD: begin
                            if (rom_idx == ROM_LAST) begin
`ifdef OLED_CLEAR_EN
                                state_next    = CLR_ADDR;
                                retry_next    = '0;
                                data_cnt_next = '0;
`else
                                state_next = FINISH;
                                done_next  = 1'b1;
`endif
                            end else begin
                                rom_idx_next = rom_idx + 5'd1;
                                state_next   = INIT_CMD;
                            end
                        end
`ifdef OLED_CLEAR_EN
                        CLR_ADDR: state_next = CLR_CTRL;
                        CLR_CTRL: state_next = CLR_DATA;
                        CLR_DATA: begin
                            if (data_cnt == DATA_LAST) begin
                                state_next = FINISH;
                                done_next  = 1'b1;
                            end else begin
                                data_cnt_next = data_cnt + 11'd1;
                                state_next    = CLR_DATA;
                            end
                        end
`endif
                        default: state_next = IDLE;
                    endcase
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Bench for oled_init_sequencer: an I2C-master model accepts bytes, checks them against a
// scoreboard queue and returns ACK/NACK; a table of scenarios drives retry, stall and status checks.
module tb_oled_init_sequencer;

    localparam int RETRY_MAX  = 3;
    localparam int INIT_BYTES = 33;
`ifdef OLED_CLEAR_EN
    localparam int CLR_BYTES  = 1026;
    localparam int ABORT_AT   = 73;
`else
    localparam int CLR_BYTES  = 0;
    localparam int ABORT_AT   = 12;
`endif
    localparam int FULL   = INIT_BYTES + CLR_BYTES;
    localparam int BUDGET = 12000;

    logic       CLK = 1'b0;
    logic       NRST = 1'b0;
    logic       go = 1'b0;
    logic       tx_ready = 1'b1;
    logic       ack_valid = 1'b0;
    logic       ack_nack = 1'b0;
    logic       tx_valid, tx_start, tx_stop, busy, done, error;
    logic [7:0] tx_byte;

    oled_init_sequencer #(.RETRY_MAX(RETRY_MAX)) dut (
        .CLK       (CLK),
        .NRST      (NRST),
        .go        (go),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_stop   (tx_stop),
        .ack_valid (ack_valid),
        .ack_nack  (ack_nack),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] data;
        logic       start;
        logic       stop;
    } beat_t;

    typedef struct {
        int nack_pos;
        int nack_times;
        bit nack_addr;
        int stall_byte;
        int stall_len;
        int go_again;
        bit exp_done;
        bit exp_error;
        int exp_bytes;
    } vec_t;

    logic [7:0] init_cmds [31] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hA1, 8'hC8,
        8'hDA, 8'h12, 8'h81, 8'h7F, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    beat_t exp_q [$];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic beat_t init_beat(input int i);
        beat_t b;
        b.start = (i == 0);
        b.stop  = (i == INIT_BYTES - 1);
        if (i == 0)      b.data = 8'h78;
        else if (i == 1) b.data = 8'h00;
        else             b.data = init_cmds[i - 2];
        return b;
    endfunction

    task automatic push_init(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(init_beat(i));
    endtask

    task automatic push_full();
        beat_t b;
        push_init(INIT_BYTES);
        for (int i = 0; i < CLR_BYTES; i++) begin
            b.start = (i == 0);
            b.stop  = (i == CLR_BYTES - 1);
            b.data  = (i == 0) ? 8'h78 : ((i == 1) ? 8'h40 : 8'h00);
            exp_q.push_back(b);
        end
    endtask

    // Master model state, shared with the main sequence.
    int         acc_idx = 0;
    int         next_pos = 0;
    int         cur_pos = 0;
    int         stall_at = -1;
    int         stall_left = 0;
    int         nack_pos = -1;
    int         nack_left = 0;
    int         idle_valid = 0;
    bit         nack_addr = 1'b0;
    bit         pending = 1'b0;
    bit         pend_nack = 1'b0;
    bit         ack_follow = 1'b0;
    bit         stall_seen = 1'b0;
    logic [7:0] held_byte = 8'h00;
    time        last_ack_t = 0;
    beat_t      got_b, want_b;

    initial begin : master_model
        forever begin
            @(negedge CLK);
            ack_valid = 1'b0;
            ack_nack  = 1'b0;
            if (tx_valid && !busy) idle_valid++;
            if (!NRST) begin
                pending    = 1'b0;
                ack_follow = 1'b0;
                tx_ready   = 1'b1;
            end else if (pending) begin
                check("valid_low_after_accept", tx_valid, 0);
                ack_valid  = 1'b1;
                ack_nack   = pend_nack;
                pending    = 1'b0;
                ack_follow = 1'b1;
                last_ack_t = $time;
            end else begin
                if (ack_follow) begin
                    ack_follow = 1'b0;
                    check("next_after_ack", (busy && tx_valid) || (!busy && (done || error)), 1);
                end
                if (tx_valid && acc_idx == stall_at && stall_left > 0) begin
                    tx_ready = 1'b0;
                    if (!stall_seen) begin
                        stall_seen = 1'b1;
                        held_byte  = tx_byte;
                    end else begin
                        check("stall_hold", tx_byte, held_byte);
                    end
                    stall_left--;
                    // A stray NACK pulse outside WAIT_ACK must be ignored.
                    if (stall_left % 2 == 0) begin
                        ack_valid = 1'b1;
                        ack_nack  = 1'b1;
                    end
                end else if (tx_valid) begin
                    tx_ready     = 1'b1;
                    got_b.data   = tx_byte;
                    got_b.start  = tx_start;
                    got_b.stop   = tx_stop;
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", exp_q.size(), 1);
                    end else begin
                        want_b = exp_q.pop_front();
                        check("byte", got_b, want_b);
                    end
                    cur_pos   = tx_start ? 0 : next_pos;
                    next_pos  = cur_pos + 1;
                    pend_nack = (nack_addr && tx_start) || (cur_pos == nack_pos && nack_left > 0);
                    if (!nack_addr && cur_pos == nack_pos && nack_left > 0) nack_left--;
                    pending = 1'b1;
                    acc_idx++;
                end else begin
                    tx_ready = 1'b1;
                end
            end
        end
    end

    task automatic start_go();
        go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        check("go_busy", busy, 1);
        check("go_valid", tx_valid, 1);
        check("go_first_byte", {tx_byte, tx_start}, {8'h78, 1'b1});
        check("go_status_clr", {done, error}, 2'b00);
    endtask

    task automatic wait_status(output int cyc);
        cyc = 0;
        while (!(done || error) && cyc < BUDGET) begin
            @(negedge CLK);
            cyc++;
        end
        check("status_timeout", cyc < BUDGET, 1);
    endtask

    vec_t vecs [6];

    initial begin : main
        int  start_acc, idle_snap, cyc;
        time status_t;

        vecs[0] = '{-1, 0, 1'b0,  0,  0,  0, 1'b1, 1'b0, FULL};
        vecs[1] = '{ 5, 1, 1'b0,  0,  0,  0, 1'b1, 1'b0, 6 + FULL};
        vecs[2] = '{-1, 0, 1'b1,  0,  0,  0, 1'b0, 1'b1, RETRY_MAX + 1};
        vecs[3] = '{-1, 0, 1'b0, 10, 20, 36, 1'b1, 1'b0, FULL};
        vecs[4] = '{ 0, 3, 1'b0,  0,  0,  0, 1'b1, 1'b0, 3 + FULL};
        vecs[5] = '{32, 1, 1'b0,  0,  0,  0, 1'b1, 1'b0, INIT_BYTES + FULL};

        repeat (3) @(negedge CLK);
        check("rst_outputs", {tx_valid, tx_start, tx_stop, busy, done, error}, 6'b0);
        check("rst_byte", tx_byte, 8'h00);
        NRST = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 6; v++) begin
            nack_pos   = vecs[v].nack_pos;
            nack_left  = vecs[v].nack_times;
            nack_addr  = vecs[v].nack_addr;
            stall_at   = (vecs[v].stall_len > 0) ? acc_idx + vecs[v].stall_byte : -1;
            stall_left = vecs[v].stall_len;
            stall_seen = 1'b0;
            start_acc  = acc_idx;
            idle_snap  = idle_valid;
            exp_q.delete();
            if (vecs[v].nack_addr) begin
                for (int i = 0; i <= RETRY_MAX; i++) push_init(1);
            end else begin
                for (int i = 0; i < vecs[v].nack_times; i++) push_init(vecs[v].nack_pos + 1);
                push_full();
            end

            start_go();
            if (vecs[v].go_again > 0) begin
                repeat (vecs[v].go_again) @(negedge CLK);
                go = 1'b1;
                @(negedge CLK);
                go = 1'b0;
                check("go_while_busy", busy, 1);
            end
            wait_status(cyc);
            status_t = $time;
            check("done", done, vecs[v].exp_done);
            check("error", error, vecs[v].exp_error);
            check("busy_end", busy, 0);
            check("status_latency", 32'(status_t - last_ack_t), 10);
            check("bytes_accepted", acc_idx - start_acc, vecs[v].exp_bytes);
            check("sb_leftover", exp_q.size(), 0);
            repeat (8) @(negedge CLK);
            check("valid_while_idle", idle_valid - idle_snap, 0);
            check("status_held", {done, error}, {vecs[v].exp_done, vecs[v].exp_error});
        end

        // Reset in the middle of a transaction, then a clean restart.
        nack_pos   = -1;
        nack_left  = 0;
        nack_addr  = 1'b0;
        stall_left = 0;
        exp_q.delete();
        push_full();
        start_acc = acc_idx;
        start_go();
        cyc = 0;
        while (acc_idx < start_acc + ABORT_AT && cyc < BUDGET) begin
            @(negedge CLK);
            cyc++;
        end
        check("abort_reach", cyc < BUDGET, 1);
        NRST = 1'b0;
        @(negedge CLK);
        check("abort_outputs", {tx_valid, tx_start, tx_stop, busy, done, error}, 6'b0);
        check("abort_byte", tx_byte, 8'h00);
        @(negedge CLK);
        NRST = 1'b1;
        @(negedge CLK);
        check("abort_idle", {tx_valid, busy}, 2'b00);
        exp_q.delete();
        push_full();
        start_acc = acc_idx;
        start_go();
        wait_status(cyc);
        check("restart_done", {done, error}, 2'b10);
        check("restart_bytes", acc_idx - start_acc, FULL);
        check("restart_leftover", exp_q.size(), 0);
        repeat (4) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
